// File: rtl/ranas_pkg.sv
// Shared encodings and constants for the frog movement logic.
package ranas_pkg;

   typedef enum logic [1:0] {
      INICIO        = 2'b00,
      LIBRE         = 2'b01,
      ESPERA_SUELTA = 2'b10
   } estado_rana_t;

   typedef enum logic [1:0] {
      DIR_NADA = 2'b00,
      DIR_INC  = 2'b01,
      DIR_DEC  = 2'b10
   } dir_t;

   localparam logic [2:0] ESTADO_JUGANDO = 3'b111;
   localparam logic [2:0] POSY_META      = 3'd7;

   localparam int POSX_INI_DEF = 3;
   localparam int POSY_INI_DEF = 0;
   localparam int POSX_MAX_DEF = 7;

endpackage

// File: rtl/ranas_paso_sat.sv
// One-step coordinate update clamped to 0..max_i; cambio_o flags a real change.
module ranas_paso_sat
   import ranas_pkg::*;
#(
   parameter int W = 3
) (
   input  logic [W-1:0] pos_i,
   input  dir_t         dir_i,
   input  logic [W-1:0] max_i,
   output logic [W-1:0] pos_o,
   output logic         cambio_o
);

   always_comb begin
      pos_o    = pos_i;
      cambio_o = 1'b0;
      case (dir_i)
         DIR_INC: begin
            if (pos_i < max_i) begin
               pos_o    = pos_i + 1'b1;
               cambio_o = 1'b1;
            end
         end
         DIR_DEC: begin
            if (pos_i != '0) begin
               pos_o    = pos_i - 1'b1;
               cambio_o = 1'b1;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/ctrol_movrana.sv
// Frog position register and movement FSM with release holdoff.
// Optional auto-repeat of a held single button: define RANA_AUTOREPEAT_EN.
module ctrol_movrana
   import ranas_pkg::*;
#(
   parameter int DATAWIDTH_ESTADO = 3,
   parameter int DATAWIDTH_POS    = 3,
   parameter int POSX_INI         = POSX_INI_DEF,
   parameter int POSY_INI         = POSY_INI_DEF,
   parameter int POSX_MAX         = POSX_MAX_DEF,
   parameter int HOLDOFF_CYCLES   = 500000,
   parameter int REPEAT_CYCLES    = 12500000
) (
   input  logic                        CIR_CLOCK_50,
   input  logic                        CIR_RESET,
   input  logic                        CIR_RANA_INI_IN,
   input  logic [DATAWIDTH_ESTADO-1:0] CIR_ESTADO_IN,
   input  logic                        CIR_BTN_UP_IN,
   input  logic                        CIR_BTN_DOWN_IN,
   input  logic                        CIR_BTN_LEFT_IN,
   input  logic                        CIR_BTN_RIGHT_IN,
   output logic [DATAWIDTH_POS-1:0]    CIR_POSX_OUT,
   output logic [DATAWIDTH_POS-1:0]    CIR_POSY_OUT,
   output logic                        CIR_MOVIO_OUT
);

   localparam int CNT_W = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
   localparam logic [CNT_W-1:0]         CNT_FIN = CNT_W'(HOLDOFF_CYCLES - 1);
   localparam logic [DATAWIDTH_POS-1:0] X_INI   = DATAWIDTH_POS'(POSX_INI);
   localparam logic [DATAWIDTH_POS-1:0] Y_INI   = DATAWIDTH_POS'(POSY_INI);
   localparam logic [DATAWIDTH_POS-1:0] X_MAX   = DATAWIDTH_POS'(POSX_MAX);
   localparam logic [DATAWIDTH_POS-1:0] Y_MAX   = DATAWIDTH_POS'(POSY_META);

   if (HOLDOFF_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_param_err
      $error("ctrol_movrana: HOLDOFF_CYCLES and REPEAT_CYCLES must be >= 1");
   end

   estado_rana_t             state_q, state_d;
   logic [DATAWIDTH_POS-1:0] posx_q, posx_d, posy_q, posy_d;
   logic [DATAWIDTH_POS-1:0] posx_sat, posy_sat;
   logic                     movio_q, movio_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic                     cambio_x, cambio_y, cambio, any, jugando, meta;
   logic [3:0]               btns;
   dir_t                     dir_x, dir_y;

   assign btns    = {CIR_BTN_UP_IN, CIR_BTN_DOWN_IN, CIR_BTN_LEFT_IN, CIR_BTN_RIGHT_IN};
   assign any     = |btns;
   assign jugando = (CIR_ESTADO_IN == DATAWIDTH_ESTADO'(ESTADO_JUGANDO));
   assign meta    = (posy_q == Y_MAX);
   assign cambio  = cambio_x | cambio_y;

   // Only the highest-priority pressed button produces a direction.
   always_comb begin
      dir_x = DIR_NADA;
      dir_y = DIR_NADA;
      if (CIR_BTN_UP_IN)        dir_y = DIR_INC;
      else if (CIR_BTN_DOWN_IN) dir_y = DIR_DEC;
      else if (CIR_BTN_LEFT_IN) dir_x = DIR_DEC;
      else if (CIR_BTN_RIGHT_IN) dir_x = DIR_INC;
   end

   ranas_paso_sat #(.W(DATAWIDTH_POS)) u_paso_x (
      .pos_i(posx_q), .dir_i(dir_x), .max_i(X_MAX), .pos_o(posx_sat), .cambio_o(cambio_x)
   );

   ranas_paso_sat #(.W(DATAWIDTH_POS)) u_paso_y (
      .pos_i(posy_q), .dir_i(dir_y), .max_i(Y_MAX), .pos_o(posy_sat), .cambio_o(cambio_y)
   );

`ifdef RANA_AUTOREPEAT_EN
   localparam int REP_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
   localparam logic [REP_W-1:0] REP_FIN = REP_W'(REPEAT_CYCLES - 1);
   logic [REP_W-1:0] rep_q, rep_d;
   logic             arm_q, arm_d;
   logic [3:0]       btn_q;
`endif

   always_comb begin
      state_d = state_q;
      posx_d  = posx_q;
      posy_d  = posy_q;
      movio_d = 1'b0;
      cnt_d   = cnt_q;
`ifdef RANA_AUTOREPEAT_EN
      rep_d   = '0;
      arm_d   = arm_q;
`endif
      if (CIR_RANA_INI_IN) begin
         state_d = INICIO;
         posx_d  = X_INI;
         posy_d  = Y_INI;
         cnt_d   = '0;
`ifdef RANA_AUTOREPEAT_EN
         arm_d   = 1'b0;
`endif
      end else begin
         case (state_q)
            INICIO: begin
               cnt_d = '0;
`ifdef RANA_AUTOREPEAT_EN
               arm_d = 1'b0;
`endif
               // A button still held when play resumes must be released first.
               if (jugando) state_d = any ? ESPERA_SUELTA : LIBRE;
            end
            LIBRE: begin
               if (!jugando) begin
                  state_d = INICIO;
               end else if (any && !meta) begin
                  posx_d  = posx_sat;
                  posy_d  = posy_sat;
                  movio_d = cambio;
                  cnt_d   = '0;
                  state_d = ESPERA_SUELTA;
`ifdef RANA_AUTOREPEAT_EN
                  arm_d   = 1'b1;
`endif
               end
            end
            ESPERA_SUELTA: begin
               if (!jugando) begin
                  state_d = INICIO;
                  cnt_d   = '0;
               end else begin
                  if (any) begin
                     cnt_d = '0;
                  end else if (cnt_q == CNT_FIN) begin
                     state_d = LIBRE;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
`ifdef RANA_AUTOREPEAT_EN
                  if (arm_q && $onehot(btns) && (btns == btn_q)) begin
                     if (rep_q == REP_FIN) begin
                        if (!meta) begin
                           posx_d  = posx_sat;
                           posy_d  = posy_sat;
                           movio_d = cambio;
                        end
                     end else begin
                        rep_d = rep_q + 1'b1;
                     end
                  end else begin
                     arm_d = 1'b0;
                  end
`endif
               end
            end
            default: state_d = INICIO;
         endcase
      end
   end

   always_ff @(posedge CIR_CLOCK_50) begin
      if (CIR_RESET) begin
         state_q <= INICIO;
         posx_q  <= X_INI;
         posy_q  <= Y_INI;
         movio_q <= 1'b0;
         cnt_q   <= '0;
`ifdef RANA_AUTOREPEAT_EN
         rep_q   <= '0;
         arm_q   <= 1'b0;
         btn_q   <= '0;
`endif
      end else begin
         state_q <= state_d;
         posx_q  <= posx_d;
         posy_q  <= posy_d;
         movio_q <= movio_d;
         cnt_q   <= cnt_d;
`ifdef RANA_AUTOREPEAT_EN
         rep_q   <= rep_d;
         arm_q   <= arm_d;
         btn_q   <= btns;
`endif
      end
   end

   assign CIR_POSX_OUT  = posx_q;
   assign CIR_POSY_OUT  = posy_q;
   assign CIR_MOVIO_OUT = movio_q;

endmodule

// File: tb/tb_ctrol_movrana.sv
// Bench for ctrol_movrana: directed vector table, randomized run against a rule-level model.
module tb_ctrol_movrana;

   localparam int HOLD = 4;
   localparam int REP  = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       ini = 1'b0;
   logic [2:0] est = 3'd0;
   logic       up = 1'b0, dn = 1'b0, lf = 1'b0, rt = 1'b0;
   logic [2:0] posx, posy;
   logic       movio;

   int n_total = 0;
   int n_pass  = 0;

   always #5 clk = ~clk;

   ctrol_movrana #(
      .HOLDOFF_CYCLES(HOLD),
      .REPEAT_CYCLES (REP)
   ) dut (
      .CIR_CLOCK_50    (clk),
      .CIR_RESET       (rst),
      .CIR_RANA_INI_IN (ini),
      .CIR_ESTADO_IN   (est),
      .CIR_BTN_UP_IN   (up),
      .CIR_BTN_DOWN_IN (dn),
      .CIR_BTN_LEFT_IN (lf),
      .CIR_BTN_RIGHT_IN(rt),
      .CIR_POSX_OUT    (posx),
      .CIR_POSY_OUT    (posy),
      .CIR_MOVIO_OUT   (movio)
   );

   typedef struct {
      int   n;
      bit   ini;
      int   est;
      bit   u, d, l, r;
      int   ex, ey;
      bit   em;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t v(int n, bit i, int e, bit u, bit d, bit l, bit r,
                              int ex, int ey, bit em);
      vec_t t;
      t.n = n; t.ini = i; t.est = e; t.u = u; t.d = d; t.l = l; t.r = r;
      t.ex = ex; t.ey = ey; t.em = em;
      return t;
   endfunction

   task automatic check(string name, int act, int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(bit i, int e, bit u, bit d, bit l, bit r);
      ini = i; est = 3'(e); up = u; dn = d; lf = l; rt = r;
   endtask

   // Reference model: rule-level description of the frog's behaviour.
   int m_x, m_y, m_quiet;
   bit m_mov, m_start, m_hold;

   task automatic model_reset();
      m_x = 3; m_y = 0; m_mov = 0; m_start = 1; m_hold = 0; m_quiet = 0;
   endtask

   function automatic int clamp(int a, int lo, int hi);
      return (a < lo) ? lo : ((a > hi) ? hi : a);
   endfunction

   task automatic model_step(bit i, int e, bit u, bit d, bit l, bit r);
      bit any, play;
      int nx, ny;
      any  = u | d | l | r;
      play = (e == 7);
      m_mov = 0;
      if (i) begin
         m_x = 3; m_y = 0; m_start = 1; m_hold = 0; m_quiet = 0;
      end else if (m_start) begin
         if (play) begin m_start = 0; m_hold = any; m_quiet = 0; end
      end else if (!play) begin
         m_start = 1; m_hold = 0; m_quiet = 0;
      end else if (m_hold) begin
         if (any) m_quiet = 0;
         else if (m_quiet == HOLD - 1) begin m_hold = 0; m_quiet = 0; end
         else m_quiet++;
      end else if (any && m_y != 7) begin
         nx = m_x; ny = m_y;
         if (u)      ny = m_y + 1;
         else if (d) ny = m_y - 1;
         else if (l) nx = m_x - 1;
         else        nx = m_x + 1;
         nx = clamp(nx, 0, 7);
         ny = clamp(ny, 0, 7);
         m_mov = (nx != m_x) || (ny != m_y);
         m_x = nx; m_y = ny; m_hold = 1; m_quiet = 0;
      end
   endtask

   task automatic do_reset();
      drive(0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      // x, y, movio after each edge; "n" repeats a row with the same expectation
      tbl.push_back(v(1, 0, 7, 0,0,0,0, 3,0,0));   // INICIO -> LIBRE
      tbl.push_back(v(1, 0, 7, 1,0,0,0, 3,1,1));   // first UP
      tbl.push_back(v(19,0, 7, 1,0,0,0, 3,1,0));   // held: no further move
      tbl.push_back(v(4, 0, 7, 0,0,0,0, 3,1,0));   // holdoff
      tbl.push_back(v(1, 0, 7, 1,0,0,0, 3,2,1));
      tbl.push_back(v(4, 0, 7, 0,0,0,0, 3,2,0));
      tbl.push_back(v(1, 0, 7, 0,0,1,0, 2,2,1));
      tbl.push_back(v(4, 0, 7, 0,0,0,0, 2,2,0));
      tbl.push_back(v(1, 0, 7, 0,0,1,0, 1,2,1));
      tbl.push_back(v(4, 0, 7, 0,0,0,0, 1,2,0));
      tbl.push_back(v(1, 0, 7, 0,0,1,0, 0,2,1));
      tbl.push_back(v(4, 0, 7, 0,0,0,0, 0,2,0));
      tbl.push_back(v(1, 0, 7, 0,0,1,0, 0,2,0));   // LEFT into wall
      tbl.push_back(v(4, 0, 7, 0,0,0,0, 0,2,0));
      tbl.push_back(v(1, 0, 7, 0,0,1,1, 0,2,0));   // LEFT beats RIGHT
      tbl.push_back(v(4, 0, 7, 0,0,0,0, 0,2,0));
      tbl.push_back(v(1, 0, 7, 0,0,0,1, 1,2,1));
      tbl.push_back(v(4, 0, 7, 0,0,0,0, 1,2,0));
      tbl.push_back(v(1, 0, 7, 0,1,1,0, 1,1,1));   // DOWN beats LEFT
      tbl.push_back(v(4, 0, 7, 0,0,0,0, 1,1,0));
      tbl.push_back(v(1, 0, 7, 1,1,0,0, 1,2,1));   // UP beats DOWN
      tbl.push_back(v(4, 0, 7, 0,0,0,0, 1,2,0));
      for (int k = 3; k <= 7; k++) begin
         tbl.push_back(v(1, 0, 7, 1,0,0,0, 1,k,1));
         tbl.push_back(v(4, 0, 7, 0,0,0,0, 1,k,0));
      end
      tbl.push_back(v(3, 0, 7, 1,0,0,0, 1,7,0));   // goal row ignores buttons
      tbl.push_back(v(3, 0, 7, 0,1,0,0, 1,7,0));
      tbl.push_back(v(2, 0, 7, 0,0,0,1, 1,7,0));
      tbl.push_back(v(1, 1, 7, 0,0,0,0, 3,0,0));   // init pulse
      tbl.push_back(v(1, 0, 7, 0,0,0,0, 3,0,0));
      tbl.push_back(v(1, 0, 7, 0,0,0,1, 4,0,1));
      tbl.push_back(v(4, 0, 7, 0,0,0,0, 4,0,0));
      tbl.push_back(v(1, 1, 7, 1,0,0,0, 3,0,0));   // init overrides UP
      tbl.push_back(v(3, 0, 7, 1,0,0,0, 3,0,0));   // still held: no move
      tbl.push_back(v(3, 0, 7, 0,0,0,0, 3,0,0));
      tbl.push_back(v(1, 0, 7, 1,0,0,0, 3,0,0));   // press inside holdoff
      tbl.push_back(v(4, 0, 7, 0,0,0,0, 3,0,0));
      tbl.push_back(v(1, 0, 7, 1,0,0,0, 3,1,1));
      tbl.push_back(v(4, 0, 7, 0,0,0,0, 3,1,0));
      tbl.push_back(v(1, 0, 2, 1,0,0,0, 3,1,0));   // not playing: frozen
      tbl.push_back(v(1, 0, 2, 0,0,0,1, 3,1,0));
      tbl.push_back(v(1, 0, 2, 0,0,0,0, 3,1,0));
      tbl.push_back(v(1, 0, 2, 0,0,1,0, 3,1,0));
      tbl.push_back(v(1, 0, 2, 0,1,0,0, 3,1,0));
      tbl.push_back(v(1, 0, 7, 0,0,0,0, 3,1,0));
      tbl.push_back(v(1, 0, 7, 0,0,1,0, 2,1,1));
      tbl.push_back(v(1, 0, 2, 0,0,0,0, 2,1,0));   // leave play during holdoff
      tbl.push_back(v(1, 0, 7, 0,0,0,0, 2,1,0));   // straight back to LIBRE
      tbl.push_back(v(1, 0, 7, 1,0,0,0, 2,2,1));
      tbl.push_back(v(4, 0, 7, 0,0,0,0, 2,2,0));

      do_reset();
      check("reset.x", posx, 3);
      check("reset.y", posy, 0);
      check("reset.movio", movio, 0);

      foreach (tbl[i]) begin
         for (int c = 0; c < tbl[i].n; c++) begin
            drive(tbl[i].ini, tbl[i].est, tbl[i].u, tbl[i].d, tbl[i].l, tbl[i].r);
            tick();
            check($sformatf("tbl%0d.%0d.x", i, c), posx, tbl[i].ex);
            check($sformatf("tbl%0d.%0d.y", i, c), posy, tbl[i].ey);
            check($sformatf("tbl%0d.%0d.movio", i, c), movio, tbl[i].em);
         end
      end

      // Randomized run against the model
      do_reset();
      model_reset();
      for (int c = 0; c < 1500; c++) begin
         bit       ri;
         int       re;
         bit [3:0] b;
         ri = ($urandom_range(0, 47) == 0);
         re = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 6)) : 7;
         b  = ($urandom_range(0, 9) < 6) ? 4'b0000 : 4'($urandom_range(1, 15));
         drive(ri, re, b[3], b[2], b[1], b[0]);
         model_step(ri, re, b[3], b[2], b[1], b[0]);
         tick();
         check($sformatf("rnd%0d.x", c), posx, m_x);
         check($sformatf("rnd%0d.y", c), posy, m_y);
         check($sformatf("rnd%0d.movio", c), movio, m_mov);
      end

`ifdef RANA_AUTOREPEAT_EN
      do_reset();
      drive(0, 7, 0, 0, 0, 0);
      tick();
      drive(0, 7, 0, 0, 0, 1);
      for (int i = 0; i < 40; i++) begin
         int ex;
         ex = (4 + i / REP > 7) ? 7 : 4 + i / REP;
         tick();
         check($sformatf("rep%0d.x", i), posx, ex);
         check($sformatf("rep%0d.movio", i), movio, ((i % REP == 0) && (4 + i / REP <= 7)) ? 1 : 0);
      end
      drive(0, 7, 0, 0, 0, 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
